// File: rtl/stream_wrr_arbiter_rr_search.sv
// Rotating first-one search over a request vector.
// Rotates requests by ptr, then finds the lowest set bit.
module stream_wrr_arbiter_rr_search #(
  parameter int unsigned N_INP = 2,
  parameter int unsigned IDX_W = 1
)(
  input  logic [N_INP-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [N_INP-1:0] w_rot;

  // (base + k) mod N_INP without a divider; base < N_INP, k < N_INP
  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] base,
    input int unsigned      k
  );
    int unsigned s;
    s = int'(base) + k;
    if (s >= N_INP) s = s - N_INP;
    return IDX_W'(s);
  endfunction

  // Rotate so that bit 0 of w_rot is the request at ptr
  always_comb begin
    w_rot = '0;
    for (int unsigned k = 0; k < N_INP; k++) begin
      w_rot[k] = i_req[wrap_add(i_ptr, k)];
    end
  end

  // Trailing-zero count: scan downward so the lowest set bit wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        o_idx   = wrap_add(i_ptr, int'(k));
      end
    end
  end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin stream arbiter.
// Burst credit per input; grant locked while stalled.
module stream_wrr_arbiter #(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 2,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W   = (N_INP > 1) ? $clog2(N_INP) : 1
)(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  DATA_T [N_INP-1:0]               inp_data_i,
  input  logic  [N_INP-1:0]               inp_valid_i,
  output logic  [N_INP-1:0]               inp_ready_o,
  input  logic  [N_INP-1:0][WEIGHT_W-1:0] weight_i,
  output DATA_T                           oup_data_o,
  output logic                            oup_valid_o,
  input  logic                            oup_ready_i,
  output logic  [IDX_W-1:0]               gnt_idx_o
);

  logic [IDX_W-1:0]    r_ptr;
  logic [WEIGHT_W-1:0] r_cnt;
  logic                r_fresh;
  logic                r_lock;
  logic [IDX_W-1:0]    r_lock_idx;

  logic [IDX_W-1:0]    w_srch_idx;
  logic                w_srch_found;
  logic [IDX_W-1:0]    w_sel;
  logic                w_valid;
  logic                w_hs;
  logic [WEIGHT_W-1:0] w_rem;
  logic [IDX_W-1:0]    w_sel_nxt;

  // A zero weight still grants one beat
  function automatic logic [WEIGHT_W-1:0] eff_w(
    input logic [WEIGHT_W-1:0] w
  );
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  stream_wrr_arbiter_rr_search #(
    .N_INP (N_INP),
    .IDX_W (IDX_W)
  ) u_search (
    .i_req   (inp_valid_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_srch_idx),
    .o_found (w_srch_found)
  );

  // Selection, handshake and remaining credit for this beat
  always_comb begin
    w_sel   = r_lock ? r_lock_idx : w_srch_idx;
    w_valid = rst_ni &
              (r_lock ? inp_valid_i[r_lock_idx] : w_srch_found);
    w_hs    = w_valid & oup_ready_i;
    if ((w_sel == r_ptr) && !r_fresh) w_rem = r_cnt;
    else                              w_rem = eff_w(weight_i[w_sel]);
    if (w_sel == IDX_W'(N_INP - 1)) w_sel_nxt = '0;
    else                            w_sel_nxt = w_sel + 1'b1;
  end

  // Output mux and one-hot ready back to the selected input
  always_comb begin
    inp_ready_o        = '0;
    inp_ready_o[w_sel] = w_hs;
    oup_valid_o        = w_valid;
    oup_data_o         = inp_data_i[w_sel];
    gnt_idx_o          = rst_ni ? w_sel : '0;
  end

  // Credit/pointer update on handshake; lock holds a stalled grant
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_fresh    <= 1'b1;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (w_hs) begin
        r_lock <= 1'b0;
        if (w_rem <= WEIGHT_W'(1)) begin
          r_ptr   <= w_sel_nxt;
          r_fresh <= 1'b1;
        end else begin
          r_ptr   <= w_sel;
          r_cnt   <= w_rem - 1'b1;
          r_fresh <= 1'b0;
        end
      end else if (w_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Testbench for stream_wrr_arbiter (N_INP=3, 8-bit data).
// Vector table plus scoreboarded grant sequences.
module tb_stream_wrr_arbiter;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0][7:0]      inp_data;
  logic [2:0]           inp_valid;
  logic [2:0]           inp_ready;
  logic [2:0][3:0]      weight;
  logic [7:0]           oup_data;
  logic                 oup_valid;
  logic                 oup_ready;
  logic [1:0]           gnt_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] v;
    logic       rdy;
    logic       ev;
    logic [1:0] eidx;
    logic [7:0] edat;
    logic [2:0] erdy;
  } vec_t;

  vec_t tbl[7];
  int   sb[$];
  logic [7:0] dat[3];

  stream_wrr_arbiter #(
    .DATA_T   (logic [7:0]),
    .N_INP    (3),
    .WEIGHT_W (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inp_data_i  (inp_data),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .weight_i    (weight),
    .oup_data_o  (oup_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .gnt_idx_o   (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic r);
    inp_valid = v;
    oup_ready = r;
    #2;
  endtask

  task automatic do_reset(input logic [3:0] w0,
                          input logic [3:0] w1,
                          input logic [3:0] w2);
    weight[0] = w0;
    weight[1] = w1;
    weight[2] = w2;
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  // Push the expected grant, drive, then pop on the observed handshake
  task automatic sb_step(input logic [2:0] v, input int exp_idx);
    int e;
    sb.push_back(exp_idx);
    drive(v, 1'b1);
    if (oup_valid && oup_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_gnt_idx", 32'(gnt_idx), 32'(e));
      chk("sb_data", 32'(oup_data), 32'(dat[e]));
    end else begin
      chk("sb_handshake", 32'(oup_valid), 32'd1);
    end
    tick();
  endtask

  task automatic sb_drain(input string nm);
    chk(nm, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int pat6[6];
    dat[0] = 8'hA5;
    dat[1] = 8'h11;
    dat[2] = 8'h22;
    inp_data[0] = dat[0];
    inp_data[1] = dat[1];
    inp_data[2] = dat[2];
    inp_valid = '0;
    oup_ready = 1'b0;
    weight    = '0;
    rst_n     = 1'b0;

    // Outputs held off while in reset
    do_reset(4'd1, 4'd1, 4'd1);
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    chk("rst_valid", 32'(oup_valid), 32'd0);
    chk("rst_ready", 32'(inp_ready), 32'd0);
    chk("rst_gnt", 32'(gnt_idx), 32'd0);
    tick();
    rst_n = 1'b1;

    //        v       rdy   ev    idx    data   readies
    tbl[0] = '{3'b100, 1'b1, 1'b1, 2'd2, 8'h22, 3'b100};
    tbl[1] = '{3'b001, 1'b0, 1'b1, 2'd0, 8'hA5, 3'b000};
    tbl[2] = '{3'b101, 1'b0, 1'b1, 2'd0, 8'hA5, 3'b000};
    tbl[3] = '{3'b101, 1'b0, 1'b1, 2'd0, 8'hA5, 3'b000};
    tbl[4] = '{3'b101, 1'b1, 1'b1, 2'd0, 8'hA5, 3'b001};
    tbl[5] = '{3'b101, 1'b1, 1'b1, 2'd2, 8'h22, 3'b100};
    tbl[6] = '{3'b000, 1'b1, 1'b0, 2'd0, 8'h00, 3'b000};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(oup_valid),
          32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_gnt", i), 32'(gnt_idx),
            32'(tbl[i].eidx));
        chk($sformatf("vec%0d_data", i), 32'(oup_data),
            32'(tbl[i].edat));
      end
      chk($sformatf("vec%0d_ready", i), 32'(inp_ready),
          32'(tbl[i].erdy));
      tick();
    end

    // Weights 1,2,3 with everything valid
    pat6 = '{0, 1, 1, 2, 2, 2};
    do_reset(4'd1, 4'd2, 4'd3);
    for (int c = 0; c < 12; c++) sb_step(3'b111, pat6[c % 6]);
    sb_drain("w123_drain");

    // Zero weight behaves as one
    do_reset(4'd1, 4'd0, 4'd1);
    for (int c = 0; c < 6; c++) sb_step(3'b111, c % 3);
    sb_drain("w101_drain");

    // Owner drops out: credit forfeited, later full reload
    do_reset(4'd1, 4'd1, 4'd3);
    sb_step(3'b100, 2);
    sb_step(3'b001, 0);
    sb_step(3'b100, 2);
    sb_step(3'b100, 2);
    sb_step(3'b100, 2);
    sb_step(3'b111, 0);
    sb_drain("forfeit_drain");

    // Reset while locked on input 1
    do_reset(4'd1, 4'd1, 4'd1);
    drive(3'b010, 1'b0);
    chk("lock1_gnt", 32'(gnt_idx), 32'd1);
    tick();
    drive(3'b111, 1'b0);
    chk("lock1_hold", 32'(gnt_idx), 32'd1);
    chk("lock1_data", 32'(oup_data), 32'(dat[1]));
    tick();
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    chk("lockrst_valid", 32'(oup_valid), 32'd0);
    chk("lockrst_ready", 32'(inp_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(3'b111, 1'b1);
    chk("post_rst_valid", 32'(oup_valid), 32'd1);
    chk("post_rst_gnt", 32'(gnt_idx), 32'd0);
    chk("post_rst_ready", 32'(inp_ready), 32'b001);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
